// File: rtl/mem_line_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_line_responder                                            |
// | Purpose  : Line-granular main-memory responder on bus 2. Accepts line    |
// |            read / line write commands, waits a fixed latency, then       |
// |            returns (read) or acknowledges (write) a full line moved as   |
// |            LINE_BEATS consecutive beats, lowest beat first.              |
// | Ports    : clk   - clock, everything sampled at posedge                  |
// |            RESET - asynchronous reset, active-low                        |
// |            A2    - line address, valid in the command cycle              |
// |            D2    - bidirectional data beats                              |
// |            C2    - bidirectional command / response                      |
// | Options  : MEM_PRELOAD_EN - when defined, the array is filled at time    |
// |            zero from $random(SEED); otherwise it starts all zeros.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_line_responder #(
  parameter int ADDR2_BUS_SIZE = 15,
  parameter int DATA2_BUS_SIZE = 16,
  parameter int CTR2_BUS_SIZE  = 2,
  parameter int LINE_BEATS     = 8,
  parameter int MEM_LINES      = 1024,
  parameter int MEM_LATENCY    = 100
`ifdef MEM_PRELOAD_EN
  , parameter int SEED         = 225526
`endif
) (
  input  logic                      clk,
  input  logic                      RESET,
  input  logic [ADDR2_BUS_SIZE-1:0] A2,
  inout  wire logic [DATA2_BUS_SIZE-1:0] D2,
  inout  wire logic [CTR2_BUS_SIZE-1:0]  C2
);

  localparam int c_LINE_W = LINE_BEATS * DATA2_BUS_SIZE;
  localparam int c_IDX_W  = $clog2(MEM_LINES);
  localparam int c_BEAT_W = $clog2(LINE_BEATS);
  localparam int c_LAT_W  = $clog2(MEM_LATENCY + 1);

  localparam logic [CTR2_BUS_SIZE-1:0] c_C2_NOP        = CTR2_BUS_SIZE'(0);
  localparam logic [CTR2_BUS_SIZE-1:0] c_C2_RESPONSE   = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] c_C2_READ_LINE  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] c_C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(LINE_BEATS - 1);
  // The counter holds k during cycle T0+k; leaving WAIT at the end of
  // T0+L-1 puts the first response cycle exactly at T0+L.
  localparam logic [c_LAT_W-1:0]  c_LAT_EXIT  = c_LAT_W'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_RECV = 3'd1,
    S_WAIT    = 3'd2,
    S_RD_SEND = 3'd3,
    S_WR_ACK  = 3'd4
  } state_t;

  // ------------------------------------------------------------------ array
`ifdef MEM_PRELOAD_EN
  typedef logic [c_LINE_W-1:0] mem_t [MEM_LINES];

  function automatic mem_t f_preload();
    mem_t v_m;
    int   v_seed;
    v_seed = SEED;
    for (int l = 0; l < MEM_LINES; l++) begin
      for (int b = 0; b < c_LINE_W / 8; b++) begin
        v_m[l][8*b +: 8] = 8'($random(v_seed));
      end
    end
    return v_m;
  endfunction

  mem_t r_mem = f_preload();
`else
  logic [c_LINE_W-1:0] r_mem [MEM_LINES] = '{default: '0};
`endif

  // ------------------------------------------------------------ datapath
  state_t                    r_state;
  logic [c_IDX_W-1:0]        r_idx;
  logic [c_BEAT_W-1:0]       r_beat;
  logic [c_LAT_W-1:0]        r_lat;
  logic                      r_is_wr;
  logic [c_LINE_W-1:0]       r_line;    // write staging line / read shift-out line
  logic                      r_c2_oe;
  logic [CTR2_BUS_SIZE-1:0]  r_c2_q;
  logic                      r_d2_oe;

  logic [c_IDX_W-1:0]        w_idx;
  logic [c_LINE_W-1:0]       w_stage_next;
  logic                      w_commit;
  logic                      w_a2_unused;

  // MEM_LINES is a power of two, so the modulo is just the low address bits.
  assign w_idx        = A2[c_IDX_W-1:0];
  assign w_a2_unused  = ^A2[ADDR2_BUS_SIZE-1:c_IDX_W];

  // Beats shift in from the top so beat 0 ends up in the lowest slice.
  assign w_stage_next = {D2, r_line[c_LINE_W-1:DATA2_BUS_SIZE]};

  // Single whole-line write on the last beat; a reset before then leaves
  // the FSM out of WR_RECV, so an aborted burst never touches the array.
  assign w_commit     = (r_state == S_WR_RECV) && (r_beat == c_LAST_BEAT);

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_idx] <= w_stage_next;
    end
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_beat  <= '0;
      r_lat   <= '0;
      r_is_wr <= 1'b0;
      r_line  <= '0;
      r_c2_oe <= 1'b0;
      r_c2_q  <= c_C2_NOP;
      r_d2_oe <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Comparisons against X/Z evaluate false, so junk is ignored.
          if (C2 == c_C2_READ_LINE) begin
            r_idx   <= w_idx;
            r_lat   <= c_LAT_W'(1);
            r_is_wr <= 1'b0;
            r_c2_oe <= 1'b1;
            r_c2_q  <= c_C2_NOP;
            r_state <= S_WAIT;
          end else if (C2 == c_C2_WRITE_LINE) begin
            r_idx   <= w_idx;
            r_line  <= w_stage_next;
            r_beat  <= c_BEAT_W'(1);
            r_lat   <= c_LAT_W'(1);
            r_is_wr <= 1'b1;
            r_state <= S_WR_RECV;
          end
        end

        S_WR_RECV: begin
          r_line <= w_stage_next;
          r_lat  <= r_lat + 1'b1;
          r_beat <= r_beat + 1'b1;
          if (r_beat == c_LAST_BEAT) begin
            r_beat  <= '0;
            r_c2_oe <= 1'b1;
            r_c2_q  <= c_C2_NOP;
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          r_lat <= r_lat + 1'b1;
          if (r_lat == c_LAT_EXIT) begin
            r_lat  <= '0;
            r_c2_q <= c_C2_RESPONSE;
            if (r_is_wr) begin
              r_state <= S_WR_ACK;
            end else begin
              // Array is read here, so any earlier commit is visible.
              r_line  <= r_mem[r_idx];
              r_beat  <= '0;
              r_d2_oe <= 1'b1;
              r_state <= S_RD_SEND;
            end
          end
        end

        S_RD_SEND: begin
          if (r_beat == c_LAST_BEAT) begin
            r_beat  <= '0;
            r_c2_oe <= 1'b0;
            r_d2_oe <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_beat <= r_beat + 1'b1;
            r_line <= r_line >> DATA2_BUS_SIZE;
          end
        end

        S_WR_ACK: begin
          r_c2_oe <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_c2_oe <= 1'b0;
          r_d2_oe <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign C2 = r_c2_oe ? r_c2_q : {CTR2_BUS_SIZE{1'bz}};
  assign D2 = r_d2_oe ? r_line[DATA2_BUS_SIZE-1:0] : {DATA2_BUS_SIZE{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_mem_line_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_line_responder                                         |
// | Purpose  : Directed self-checking bench for mem_line_responder. The      |
// |            bus nets carry pulls (D2 high, C2 low) so a released bus      |
// |            reads as D2=FFFF, C2=0.                                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mem_line_responder;

  localparam int L = 100;

  localparam logic [1:0] C_NOP  = 2'd0;
  localparam logic [1:0] C_RESP = 2'd1;
  localparam logic [1:0] C_RD   = 2'd2;
  localparam logic [1:0] C_WR   = 2'd3;

  logic        clk = 1'b0;
  logic        RESET;
  logic [14:0] A2;
  tri1  [15:0] D2;
  tri0  [1:0]  C2;

  logic [15:0] tb_d2;
  logic        tb_d2_oe;
  logic [1:0]  tb_c2;
  logic        tb_c2_oe;

  assign D2 = tb_d2_oe ? tb_d2 : 16'hzzzz;
  assign C2 = tb_c2_oe ? tb_c2 : 2'bzz;

  int n_checks = 0;
  int n_errors = 0;

  mem_line_responder dut (
    .clk   (clk),
    .RESET (RESET),
    .A2    (A2),
    .D2    (D2),
    .C2    (C2)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Moves to just after the posedge that starts the next cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_line(input logic [15:0] base, input logic [15:0] step);
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[16*i +: 16] = base + 16'(i) * step;
    return v;
  endfunction

  task automatic do_read(input logic [14:0] addr, input logic [127:0] exp_line,
                         input int abort_beat);
    next_cycle();
    A2 = addr; tb_c2 = C_RD; tb_c2_oe = 1'b1;
    @(negedge clk);
    for (int k = 1; k < L; k++) begin
      next_cycle();
      tb_c2_oe = 1'b0;
      A2 = 15'($urandom);
      @(negedge clk);
      chk_eq("rd_wait_c2", 32'(C2), 32'(C_NOP));
      chk_eq("rd_wait_d2", 32'(D2), 32'hFFFF);
    end
    for (int b = 0; b < 8; b++) begin
      next_cycle();
      @(negedge clk);
      chk_eq("rd_resp_c2", 32'(C2), 32'(C_RESP));
      chk_eq("rd_beat", 32'(D2), 32'(exp_line[16*b +: 16]));
      if (b == abort_beat) begin
        #1 RESET = 1'b0;
        #1;
        chk_eq("rd_abort_c2", 32'(C2), 32'(C_NOP));
        chk_eq("rd_abort_d2", 32'(D2), 32'hFFFF);
        @(posedge clk);
        #1 RESET = 1'b1;
        return;
      end
    end
    next_cycle();
    @(negedge clk);
    chk_eq("rd_rel_c2", 32'(C2), 32'(C_NOP));
    chk_eq("rd_rel_d2", 32'(D2), 32'hFFFF);
  endtask

  task automatic do_write(input logic [14:0] addr, input logic [127:0] line,
                          input int abort_after);
    next_cycle();
    A2 = addr; tb_c2 = C_WR; tb_c2_oe = 1'b1;
    tb_d2 = line[15:0]; tb_d2_oe = 1'b1;
    @(negedge clk);
    chk_eq("wr_bus_d2", 32'(D2), 32'(line[15:0]));
    for (int b = 1; b < 8; b++) begin
      next_cycle();
      if (b == abort_after + 1) begin
        RESET = 1'b0;
        tb_c2_oe = 1'b0; tb_d2_oe = 1'b0;
        #1;
        chk_eq("wr_abort_c2", 32'(C2), 32'(C_NOP));
        chk_eq("wr_abort_d2", 32'(D2), 32'hFFFF);
        @(negedge clk);
        #1 RESET = 1'b1;
        return;
      end
      tb_d2 = line[16*b +: 16];
      A2 = 15'($urandom);
      @(negedge clk);
      chk_eq("wr_bus_d2", 32'(D2), 32'(line[16*b +: 16]));
      chk_eq("wr_bus_c2", 32'(C2), 32'(C_WR));
    end
    for (int k = 8; k < L; k++) begin
      next_cycle();
      tb_c2_oe = 1'b0; tb_d2_oe = 1'b0;
      @(negedge clk);
      chk_eq("wr_wait_c2", 32'(C2), 32'(C_NOP));
      chk_eq("wr_wait_d2", 32'(D2), 32'hFFFF);
    end
    next_cycle();
    @(negedge clk);
    chk_eq("wr_ack_c2", 32'(C2), 32'(C_RESP));
    next_cycle();
    @(negedge clk);
    chk_eq("wr_rel_c2", 32'(C2), 32'(C_NOP));
    chk_eq("wr_rel_d2", 32'(D2), 32'hFFFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [127:0] v_l12, v_wrap, v_aaaa, v_55;
    v_l12  = mk_line(16'h1111, 16'h1111);
    v_wrap = mk_line(16'h5A00, 16'h0001);
    v_aaaa = {8{16'hAAAA}};
    v_55   = mk_line(16'h5500, 16'h0011);

    RESET = 1'b1; A2 = '0;
    tb_d2 = '0; tb_d2_oe = 1'b0; tb_c2 = C_NOP; tb_c2_oe = 1'b0;
    #2 RESET = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_c2", 32'(C2), 32'(C_NOP));
    chk_eq("rst_d2", 32'(D2), 32'hFFFF);
    next_cycle();
    RESET = 1'b1;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      @(negedge clk);
      chk_eq("idle_c2", 32'(C2), 32'(C_NOP));
      chk_eq("idle_d2", 32'(D2), 32'hFFFF);
    end

    do_read(15'h0005, '0, -1);

    // Non-commands on C2 while idle must be ignored.
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      A2 = 15'h0012;
      tb_c2 = (i < 3) ? C_RESP : C_NOP; tb_c2_oe = 1'b1;
      @(negedge clk);
      chk_eq("ign_c2", 32'(C2), 32'(tb_c2));
      chk_eq("ign_d2", 32'(D2), 32'hFFFF);
    end
    tb_c2_oe = 1'b0;

    do_write(15'h0012, v_l12, -1);
    do_read(15'h0012, v_l12, -1);

    do_write(15'h0413, v_wrap, -1);
    do_read(15'h0013, v_wrap, -1);

    do_write(15'h0020, v_aaaa, -1);
    do_write(15'h0020, v_55, 3);
    do_read(15'h0020, v_aaaa, -1);

    do_read(15'h0012, v_l12, 2);
    do_read(15'h0012, v_l12, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
